// File: rtl/mario_anim_sel.sv
// mario_anim_sel: picks Mario's pose and facing once per video frame, then
// muxes the matching sprite ROM pixel into a registered colour + valid pair.
module mario_anim_sel #(
  parameter int          FRAMES_PER_STEP = 6,
  parameter logic [23:0] TRANSPARENT     = 24'hFF00FF,
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [31:0] keycode,
  input  logic        mario_alive,
  input  logic        mario_in_air,
  input  logic        mario,
  input  logic [23:0] mario_sr,
  input  logic [23:0] mario_sl,
  input  logic [23:0] mario_rr1,
  input  logic [23:0] mario_rr2,
  input  logic [23:0] mario_rr3,
  input  logic [23:0] mario_rl1,
  input  logic [23:0] mario_rl2,
  input  logic [23:0] mario_rl3,
  input  logic [23:0] mario_jr,
  input  logic [23:0] mario_jl,
  input  logic [23:0] mario_die,
  output logic [23:0] mario_pic_out,
  output logic        mario_pix_valid,
  output logic        facing_left,
  output logic [2:0]  anim_state
);

  // Step counter needs at least one bit even when every tick advances.
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [2:0] {
    ST_STAND = 3'd0,
    ST_WALK1 = 3'd1,
    ST_WALK2 = 3'd2,
    ST_WALK3 = 3'd3,
    ST_JUMP  = 3'd4,
    ST_DEAD  = 3'd5
  } state_t;

  // Sprite ROM selection for a given pose and facing; DEAD ignores facing.
  function automatic logic [23:0] pick_pixel(
    input state_t      st,
    input logic        fl,
    input logic [23:0] sr,
    input logic [23:0] sl,
    input logic [23:0] rr1,
    input logic [23:0] rr2,
    input logic [23:0] rr3,
    input logic [23:0] rl1,
    input logic [23:0] rl2,
    input logic [23:0] rl3,
    input logic [23:0] jr,
    input logic [23:0] jl,
    input logic [23:0] die
  );
    logic [23:0] px;
    case (st)
      ST_STAND: px = fl ? sl  : sr;
      ST_WALK1: px = fl ? rl1 : rr1;
      ST_WALK2: px = fl ? rl2 : rr2;
      ST_WALK3: px = fl ? rl3 : rr3;
      ST_JUMP:  px = fl ? jl  : jr;
      ST_DEAD:  px = die;
      default:  px = fl ? sl  : sr;
    endcase
    return px;
  endfunction

  // Walk phase successor: WALK1 -> WALK2 -> WALK3 -> WALK1.
  function automatic state_t next_walk(input state_t st);
    state_t nx;
    case (st)
      ST_WALK1: nx = ST_WALK2;
      ST_WALK2: nx = ST_WALK3;
      default:  nx = ST_WALK1;
    endcase
    return nx;
  endfunction

  logic             fclk_p0;
  logic             fclk_p1;
  logic             fclk_p2;
  logic             tick_p3;

  logic             key_left;
  logic             key_right;
  logic             walking;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             face_q;
  logic             face_nxt;

  logic [23:0]      sel_pix_p0;
  logic [23:0]      pic_p1;
  logic             vld_p1;

  // Stage p0..p2: two-flop synchroniser for VGA_VS plus a history flop.
  // Stage p3: registered rising-edge pulse, one Clk wide per frame.
  // Bring frame_clk into the Clk domain and register its rising edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fclk_p0 <= 1'b0;
      fclk_p1 <= 1'b0;
      fclk_p2 <= 1'b0;
      tick_p3 <= 1'b0;
    end else begin
      fclk_p0 <= frame_clk;
      fclk_p1 <= fclk_p0;
      fclk_p2 <= fclk_p1;
      tick_p3 <= fclk_p1 & ~fclk_p2;
    end
  end

  // Look for the left/right usage codes in any of the four key slots.
  always_comb begin
    key_left  = 1'b0;
    key_right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == KEY_LEFT)  key_left  = 1'b1;
      if (keycode[8*i +: 8] == KEY_RIGHT) key_right = 1'b1;
    end
    walking = key_left ^ key_right;
  end

  // Pose/facing next-state logic, evaluated only on the frame tick.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    face_nxt  = face_q;
    if (tick_p3) begin
      if (walking) face_nxt = key_left;

      if (state_q == ST_DEAD || !mario_alive) begin
        // Death wins over everything and only Reset brings Mario back.
        state_nxt = ST_DEAD;
      end else if (mario_in_air) begin
        state_nxt = ST_JUMP;
        cnt_nxt   = '0;
      end else if (walking) begin
        if (state_q == ST_STAND || state_q == ST_JUMP) begin
          state_nxt = ST_WALK1;
          cnt_nxt   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = next_walk(state_q);
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_q + 1'b1;
        end
      end else begin
        state_nxt = ST_STAND;
        cnt_nxt   = '0;
      end
    end
  end

  // Animation state, step counter and facing registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_STAND;
      cnt_q   <= '0;
      face_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      face_q  <= face_nxt;
    end
  end

  // Choose the ROM word for the current pixel from the registered pose.
  always_comb begin
    sel_pix_p0 = pick_pixel(state_q, face_q,
                            mario_sr, mario_sl,
                            mario_rr1, mario_rr2, mario_rr3,
                            mario_rl1, mario_rl2, mario_rl3,
                            mario_jr, mario_jl, mario_die);
  end

  // Stage p1: single register between ROM data and the colour mapper.
  // Register the pixel; blank it outside Mario's box, drop transparent texels.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pic_p1 <= 24'h000000;
      vld_p1 <= 1'b0;
    end else begin
      pic_p1 <= mario ? sel_pix_p0 : 24'h000000;
      vld_p1 <= mario && (sel_pix_p0 != TRANSPARENT);
    end
  end

  assign mario_pic_out   = pic_p1;
  assign mario_pix_valid = vld_p1;
  assign facing_left     = face_q;
  assign anim_state      = state_q;

endmodule

// File: tb/tb_mario_anim_sel.sv
// Table-driven bench for mario_anim_sel: one frame tick per table entry,
// then directed sequences for reset, transparency, latency and frame_clk edges.
`timescale 1ns/1ps
module tb_mario_anim_sel;

  localparam logic [23:0] C_SR  = 24'h123456;
  localparam logic [23:0] C_SL  = 24'h5A5A01;
  localparam logic [23:0] C_RR1 = 24'h010101;
  localparam logic [23:0] C_RR2 = 24'h020202;
  localparam logic [23:0] C_RR3 = 24'h030303;
  localparam logic [23:0] C_RL1 = 24'h0A0A01;
  localparam logic [23:0] C_RL2 = 24'h0A0A02;
  localparam logic [23:0] C_RL3 = 24'h0A0A03;
  localparam logic [23:0] C_JR  = 24'h0C0C01;
  localparam logic [23:0] C_JL  = 24'h0C0C02;
  localparam logic [23:0] C_DIE = 24'h0D0D0D;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic [31:0] keycode = 32'h0;
  logic        mario_alive = 1'b1;
  logic        mario_in_air = 1'b0;
  logic        mario = 1'b1;
  logic [23:0] mario_sr = C_SR, mario_sl = C_SL;
  logic [23:0] mario_rr1 = C_RR1, mario_rr2 = C_RR2, mario_rr3 = C_RR3;
  logic [23:0] mario_rl1 = C_RL1, mario_rl2 = C_RL2, mario_rl3 = C_RL3;
  logic [23:0] mario_jr = C_JR, mario_jl = C_JL, mario_die = C_DIE;
  logic [23:0] mario_pic_out;
  logic        mario_pix_valid;
  logic        facing_left;
  logic [2:0]  anim_state;

  int n_vec = 0;
  int n_err = 0;

  mario_anim_sel dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .mario_alive(mario_alive), .mario_in_air(mario_in_air), .mario(mario),
    .mario_sr(mario_sr), .mario_sl(mario_sl),
    .mario_rr1(mario_rr1), .mario_rr2(mario_rr2), .mario_rr3(mario_rr3),
    .mario_rl1(mario_rl1), .mario_rl2(mario_rl2), .mario_rl3(mario_rl3),
    .mario_jr(mario_jr), .mario_jl(mario_jl), .mario_die(mario_die),
    .mario_pic_out(mario_pic_out), .mario_pix_valid(mario_pix_valid),
    .facing_left(facing_left), .anim_state(anim_state)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic [31:0] key;
    logic        alive;
    logic        air;
    logic [2:0]  st;
    logic        fl;
    logic [23:0] pic;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] k, input logic a, input logic ai,
                     input logic [2:0] s, input logic f, input logic [23:0] p);
    vec_t v;
    v.key = k; v.alive = a; v.air = ai; v.st = s; v.fl = f; v.pic = p;
    tbl.push_back(v);
  endtask

  // One clean frame_clk pulse, long enough for tick and state update.
  task automatic frame_tick();
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
  endtask

  task automatic chk_pose(input string nm, input logic [2:0] s, input logic f,
                          input logic [23:0] p, input logic v);
    chk({nm, ".state"}, 32'(anim_state), 32'(s));
    chk({nm, ".facing"}, 32'(facing_left), 32'(f));
    chk({nm, ".pic"}, 32'(mario_pic_out), 32'(p));
    chk({nm, ".valid"}, 32'(mario_pix_valid), 32'(v));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  walk_st [20];
    logic [23:0] walk_px [20];
    walk_st = '{3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd2,3'd2,3'd2,3'd2,
                3'd2,3'd2,3'd3,3'd3,3'd3,3'd3,3'd3,3'd3,3'd1,3'd1};
    walk_px = '{C_RR1,C_RR1,C_RR1,C_RR1,C_RR1,C_RR1,C_RR2,C_RR2,C_RR2,C_RR2,
                C_RR2,C_RR2,C_RR3,C_RR3,C_RR3,C_RR3,C_RR3,C_RR3,C_RR1,C_RR1};

    // Idle frames: stand facing right.
    for (int i = 0; i < 3; i++) add(32'h0, 1'b1, 1'b0, 3'd0, 1'b0, C_SR);
    // Walk right for 20 frames, six frames per walk step.
    for (int i = 0; i < 20; i++) add(32'h00000007, 1'b1, 1'b0, walk_st[i], 1'b0, walk_px[i]);
    // Reverse mid-walk: facing flips, phase continues in WALK1.
    add(32'h00000400, 1'b1, 1'b0, 3'd1, 1'b1, C_RL1);
    // Both keys: stand, facing held.
    add(32'h00070004, 1'b1, 1'b0, 3'd0, 1'b1, C_SL);
    add(32'h00000007, 1'b1, 1'b0, 3'd1, 1'b0, C_RR1);
    add(32'h00000007, 1'b1, 1'b1, 3'd4, 1'b0, C_JR);
    // Dead and airborne together: dead wins.
    add(32'h00000007, 1'b0, 1'b1, 3'd5, 1'b0, C_DIE);
    // Alive again but still dead; die sprite regardless of facing.
    for (int i = 0; i < 5; i++) add(32'h00000000, 1'b1, 1'b0, 3'd5, 1'b0, C_DIE);
    for (int i = 0; i < 5; i++) add(32'h04000000, 1'b1, 1'b0, 3'd5, 1'b1, C_DIE);

    // Reset state while Reset is still held low.
    #35;
    chk_pose("reset", 3'd0, 1'b0, 24'h0, 1'b0);
    @(negedge Clk) Reset = 1'b1;

    foreach (tbl[i]) begin
      keycode = tbl[i].key;
      mario_alive = tbl[i].alive;
      mario_in_air = tbl[i].air;
      frame_tick();
      chk_pose($sformatf("vec%0d", i), tbl[i].st, tbl[i].fl, tbl[i].pic, 1'b1);
    end

    // Only Reset leaves DEAD; then walk left into WALK2.
    @(negedge Clk) Reset = 1'b0;
    @(negedge Clk) Reset = 1'b1;
    mario_alive = 1'b1; mario_in_air = 1'b0; keycode = 32'h00000004;
    for (int i = 0; i < 7; i++) frame_tick();
    chk_pose("walk2_left", 3'd2, 1'b1, C_RL2, 1'b1);

    // Asynchronous reset mid-cycle: outputs clear before the next Clk edge.
    @(posedge Clk); #3 Reset = 1'b0;
    #2;
    chk_pose("async_rst", 3'd0, 1'b0, 24'h0, 1'b0);
    @(negedge Clk) Reset = 1'b1;

    // First tick after reset is evaluated normally.
    frame_tick();
    chk_pose("post_rst", 3'd1, 1'b1, C_RL1, 1'b1);
    keycode = 32'h0;
    frame_tick();
    chk_pose("stand_left", 3'd0, 1'b1, C_SL, 1'b1);

    // Transparent texel inside the box and blanking outside it.
    mario_sl = 24'hFF00FF;
    @(posedge Clk); #1;
    chk("transp.pic", 32'(mario_pic_out), 32'hFF00FF);
    chk("transp.valid", 32'(mario_pix_valid), 32'h0);
    mario = 1'b0; mario_sl = 24'h00AA00;
    @(posedge Clk); #1;
    chk("outside.pic", 32'(mario_pic_out), 32'h0);
    chk("outside.valid", 32'(mario_pix_valid), 32'h0);

    // Exactly one register stage from ROM data to output.
    mario = 1'b1; mario_sl = C_SL;
    @(posedge Clk); #1;
    mario_sl = 24'h777777;
    #2;
    chk("lat.before", 32'(mario_pic_out), 32'(C_SL));
    @(posedge Clk); #1;
    chk("lat.after", 32'(mario_pic_out), 32'h777777);
    mario_sl = C_SL;

    // frame_clk held high yields a single tick.
    keycode = 32'h00000007;
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (100) @(posedge Clk);
    #1;
    chk_pose("held_high", 3'd1, 1'b0, C_RR1, 1'b1);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    for (int i = 0; i < 4; i++) frame_tick();
    chk("walk_cnt4.state", 32'(anim_state), 32'd1);

    // One-Clk glitch: at most one tick, so the step cannot wrap yet.
    @(posedge Clk); #3 frame_clk = 1'b1;
    @(posedge Clk); #3 frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    chk("glitch.state", 32'(anim_state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
